// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bin analyzer slice.
// Default sizes, FSM state encoding and magnitude type.
package fft_pkg;

    localparam int FFT_DW     = 8;
    localparam int FFT_N_BINS = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    typedef logic [FFT_DW-1:0] mag_t;

endpackage

// File: rtl/fft_mag_approx.sv
// Alpha-max-plus-beta-min magnitude estimate of one complex sample.
// mag = max(|re|,|im|) + min(|re|,|im|)/2, truncating; never overflows DW.
module fft_mag_approx #(
    parameter int DW = 8
) (
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic        [DW-1:0] mag
);

    logic [DW-1:0] abs_re;
    logic [DW-1:0] abs_im;
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;

    // Unsigned DW-bit magnitudes hold |-2^(DW-1)| exactly; sum stays below 2^DW.
    always_comb begin
        abs_re = re[DW-1] ? DW'(-re) : DW'(re);
        abs_im = im[DW-1] ? DW'(-im) : DW'(im);
        mx     = (abs_re >= abs_im) ? abs_re : abs_im;
        mn     = (abs_re >= abs_im) ? abs_im : abs_re;
        mag    = mx + (mn >> 1);
    end

endmodule

// File: rtl/fft_bin_analyzer.sv
// Collects one frame of FFT bins, buffers their magnitudes, tracks the peak
// and holds the frame result until the consumer acknowledges it.
module fft_bin_analyzer
    import fft_pkg::*;
#(
    parameter int DW     = FFT_DW,
    parameter int N_BINS = FFT_N_BINS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DW-1:0]         in_re,
    input  logic signed [DW-1:0]         in_im,
    input  logic                         in_last,
    input  logic                         flush,
    output logic                         result_valid,
    input  logic                         result_ack,
    input  logic [$clog2(N_BINS)-1:0]    rd_addr,
    output logic [DW-1:0]                rd_mag,
    output logic [$clog2(N_BINS)-1:0]    peak_idx,
    output logic [DW-1:0]                peak_mag,
    output logic [$clog2(N_BINS+1)-1:0]  bin_count,
    output logic                         frame_err
);

    localparam int AW = $clog2(N_BINS);
    localparam int CW = $clog2(N_BINS+1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mag;
    logic [DW-1:0] mag_buf [N_BINS];
    logic          accept;
    logic          last_slot;
    logic          close;
    logic          clr;

    fft_mag_approx #(
        .DW (DW)
    ) u_mag (
        .re  (in_re),
        .im  (in_im),
        .mag (mag)
    );

    assign accept    = in_valid && in_ready;
    assign last_slot = (cnt == AW'(N_BINS-1));
    assign close     = accept && (in_last || last_slot);
    assign clr       = flush || ((state == HOLD) && result_ack);
    assign rd_mag    = mag_buf[rd_addr];

    // Frame FSM: collect beats, close on in_last or full buffer, hold until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= COLLECT;
            in_ready     <= 1'b0;
            result_valid <= 1'b0;
            cnt          <= '0;
            peak_idx     <= '0;
            peak_mag     <= '0;
            bin_count    <= '0;
            frame_err    <= 1'b0;
            for (int i = 0; i < N_BINS; i++) begin
                mag_buf[i] <= '0;
            end
        end else if (clr) begin
            state        <= COLLECT;
            in_ready     <= 1'b1;
            result_valid <= 1'b0;
            cnt          <= '0;
            peak_idx     <= '0;
            peak_mag     <= '0;
            bin_count    <= '0;
            frame_err    <= 1'b0;
            for (int i = 0; i < N_BINS; i++) begin
                mag_buf[i] <= '0;
            end
        end else begin
            unique case (state)
                COLLECT: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mag_buf[cnt] <= mag;
                        cnt          <= cnt + AW'(1);
                        if (mag > peak_mag) begin
                            peak_mag <= mag;
                            peak_idx <= cnt;
                        end
                    end
                    if (close) begin
                        state        <= HOLD;
                        in_ready     <= 1'b0;
                        result_valid <= 1'b1;
                        bin_count    <= CW'(cnt) + CW'(1);
                        frame_err    <= (in_last != last_slot);
                    end
                end
                HOLD: begin
                    in_ready     <= 1'b0;
                    result_valid <= 1'b1;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bin_analyzer.sv
// Self-checking bench for fft_bin_analyzer: table-driven frames with a
// magnitude scoreboard, plus hand-written backpressure/flush/reset sequences.
module tb_fft_bin_analyzer;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 in_last;
    logic                 flush;
    logic                 result_valid;
    logic                 result_ack;
    logic [AW-1:0]        rd_addr;
    logic [DW-1:0]        rd_mag;
    logic [AW-1:0]        peak_idx;
    logic [DW-1:0]        peak_mag;
    logic [CW-1:0]        bin_count;
    logic                 frame_err;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 last;
        logic [DW-1:0]        mag;
    } beat_t;

    typedef struct {
        int first;
        int n;
        int pidx;
        int pmag;
        int cnt;
        int err;
    } frame_t;

    beat_t  bt [15];
    frame_t ft [5];
    int     exp_q [$];
    int     n_tests = 0;
    int     n_fail  = 0;

    fft_bin_analyzer #(
        .DW     (DW),
        .N_BINS (NB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_re        (in_re),
        .in_im        (in_im),
        .in_last      (in_last),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .rd_addr      (rd_addr),
        .rd_mag       (rd_mag),
        .peak_idx     (peak_idx),
        .peak_mag     (peak_mag),
        .bin_count    (bin_count),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk(int re, int im, bit l, int m);
        beat_t b;
        b.re   = DW'(re);
        b.im   = DW'(im);
        b.last = l;
        b.mag  = DW'(m);
        return b;
    endfunction

    function automatic frame_t mkf(int f, int n, int pi, int pm, int c, int e);
        frame_t r;
        r.first = f;
        r.n     = n;
        r.pidx  = pi;
        r.pmag  = pm;
        r.cnt   = c;
        r.err   = e;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle(string tag);
        check({tag, "_rv"}, int'(result_valid), 0);
        check({tag, "_pmag"}, int'(peak_mag), 0);
        check({tag, "_pidx"}, int'(peak_idx), 0);
        check({tag, "_cnt"}, int'(bin_count), 0);
        check({tag, "_err"}, int'(frame_err), 0);
        for (int a = 0; a < NB; a++) begin
            rd_addr = AW'(a);
            #1;
            check({tag, "_buf"}, int'(rd_mag), 0);
        end
    endtask

    // Drives one frame from the table starting at a negedge; ends at a negedge.
    task automatic send_frame(int f);
        beat_t b;
        for (int i = 0; i < ft[f].n; i++) begin
            b        = bt[ft[f].first + i];
            in_valid = 1'b1;
            in_re    = b.re;
            in_im    = b.im;
            in_last  = b.last;
            exp_q.push_back(int'(b.mag));
            check("beat_ready", int'(in_ready), 1);
            check("rv_early", int'(result_valid), 0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("rv_latency", int'(result_valid), 1);
        check("hold_ready", int'(in_ready), 0);
    endtask

    task automatic check_result(int f);
        int e;
        for (int a = 0; a < NB; a++) begin
            rd_addr = AW'(a);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
            check("rd_mag", int'(rd_mag), e);
        end
        check("peak_idx", int'(peak_idx), ft[f].pidx);
        check("peak_mag", int'(peak_mag), ft[f].pmag);
        check("bin_count", int'(bin_count), ft[f].cnt);
        check("frame_err", int'(frame_err), ft[f].err);
    endtask

    task automatic do_ack();
        @(negedge clk);
        result_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ack = 1'b0;
        check("ack_ready", int'(in_ready), 1);
        check_idle("ack");
    endtask

    initial begin
        bt[0]  = mk(10, 0, 0, 10);
        bt[1]  = mk(64, -32, 0, 80);
        bt[2]  = mk(-128, -128, 0, 192);
        bt[3]  = mk(0, 5, 1, 5);
        bt[4]  = mk(0, 40, 0, 40);
        bt[5]  = mk(40, 0, 0, 40);
        bt[6]  = mk(-40, 0, 0, 40);
        bt[7]  = mk(0, -40, 1, 40);
        bt[8]  = mk(-128, 0, 0, 128);
        bt[9]  = mk(3, 3, 1, 4);
        bt[10] = mk(1, 2, 0, 2);
        bt[11] = mk(-7, 4, 0, 9);
        bt[12] = mk(100, -100, 0, 150);
        bt[13] = mk(-1, -1, 0, 1);
        bt[14] = mk(127, -128, 1, 191);
        ft[0]  = mkf(0, 4, 2, 192, 4, 0);
        ft[1]  = mkf(4, 4, 0, 40, 4, 0);
        ft[2]  = mkf(8, 2, 0, 128, 2, 1);
        ft[3]  = mkf(10, 4, 2, 150, 4, 1);
        ft[4]  = mkf(14, 1, 0, 191, 1, 1);

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_re      = '0;
        in_im      = '0;
        in_last    = 1'b0;
        flush      = 1'b0;
        result_ack = 1'b0;
        rd_addr    = '0;

        #12;
        check("rst_ready", int'(in_ready), 0);
        check_idle("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", int'(in_ready), 1);

        for (int f = 0; f < 5; f++) begin
            send_frame(f);
            check_result(f);
            do_ack();
        end

        // Backpressure in HOLD, then beat offered during the ack cycle.
        send_frame(0);
        check_result(0);
        in_valid = 1'b1;
        in_re    = 8'sd20;
        in_im    = 8'sd0;
        in_last  = 1'b0;
        rd_addr  = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_ready", int'(in_ready), 0);
            check("bp_count", int'(bin_count), 4);
            check("bp_buf0", int'(rd_mag), 10);
        end
        result_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ack = 1'b0;
        check("ackcyc_ready", int'(in_ready), 1);
        check("ackcyc_buf0", int'(rd_mag), 0);
        check("ackcyc_rv", int'(result_valid), 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("after_ack_buf0", int'(rd_mag), 20);
        check("after_ack_peak", int'(peak_mag), 20);

        // Flush clears the partial beat above.
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_idle("flush0");

        // Flush after two beats, with a competing beat on the flush edge.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_re    = bt[i].re;
            in_im    = bt[i].im;
            in_last  = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        rd_addr = 2'd1;
        #1;
        check("partial_buf1", int'(rd_mag), 80);
        check("partial_pidx", int'(peak_idx), 1);
        check("partial_pmag", int'(peak_mag), 80);
        in_re = 8'sd50;
        in_im = 8'sd0;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_ready", int'(in_ready), 1);
        check_idle("flush2");
        send_frame(0);
        check_result(0);
        do_ack();

        // Reset asserted while holding a short frame.
        send_frame(2);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("rsthold_ready", int'(in_ready), 0);
        check_idle("rsthold");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        send_frame(0);
        check_result(0);
        do_ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
